// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg: shared states and funct codes for the mul/div unit.
// Optional feature macro used by the unit: MULDIV_EARLY_OUT_EN.
package mips_cpu_muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Divide by zero leaves LO filled with this bit (all ones).
  localparam logic DZ_LO_FILL = 1'b1;

endpackage

// File: rtl/mips_cpu_muldiv_signfix.sv
// mips_cpu_muldiv_signfix: sign correction of the unsigned mul/div core result.
// Produces the final HI/LO values written when the unit leaves FIX.
module mips_cpu_muldiv_signfix
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic               neg_i,
  input  logic               rneg_i,
  input  logic               dz_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Negate product/quotient/remainder as the latched sign flags demand.
  always_comb begin
    prod = neg_i ? -acc_i : acc_i;
    quo  = acc_i[WIDTH-1:0];
    rem  = acc_i[2*WIDTH-1:WIDTH];
    hi_o = prod[2*WIDTH-1:WIDTH];
    lo_o = prod[WIDTH-1:0];
    if (is_div_i) begin
      hi_o = rneg_i ? -rem : rem;
      lo_o = neg_i ? -quo : quo;
      if (dz_i) lo_o = {WIDTH{DZ_LO_FILL}};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the multiplier runs out.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic               neg_q;
  logic               rneg_q;
  logic               dz_q;
  logic               is_div_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_mul;
  logic               is_div;
  logic               is_sgn;
  logic               any_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_d;
  logic [2*WIDTH-1:0] mul_d;
  logic               mul_last;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Decode, operand magnitudes and one shift-add / shift-subtract step.
  always_comb begin
    is_mul  = (funct == F_MULT) || (funct == F_MULTU);
    is_div  = (funct == F_DIV) || (funct == F_DIVU);
    is_sgn  = (funct == F_MULT) || (funct == F_DIV);
    any_op  = is_mul || is_div ||
              (funct == F_MTHI) || (funct == F_MTLO) ||
              (funct == F_MFHI) || (funct == F_MFLO);
    a_abs   = (is_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    b_abs   = (is_sgn && op_b[WIDTH-1]) ? -op_b : op_b;
    div_tmp = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_sub = div_tmp - {1'b0, mcand_q[WIDTH-1:0]};
    div_ge  = div_tmp >= {1'b0, mcand_q[WIDTH-1:0]};
    div_d   = div_ge ?
              {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1} :
              {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    mul_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
`ifdef MULDIV_EARLY_OUT_EN
    mul_last = (mplr_q[WIDTH-1:1] == '0) || (cnt_q == LAST);
`else
    mul_last = (cnt_q == LAST);
`endif
  end

  assign busy   = (state_q != S_IDLE);
  assign ready  = !busy;
  assign stall  = valid && busy && any_op;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  mips_cpu_muldiv_signfix #(
    .WIDTH(WIDTH)
  ) u_signfix (
    .is_div_i(is_div_q),
    .neg_i   (neg_q),
    .rneg_i  (rneg_q),
    .dz_i    (dz_q),
    .acc_i   (acc_q),
    .hi_o    (fix_hi),
    .lo_o    (fix_lo)
  );

  // Control FSM, iteration datapath and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (valid && (is_mul || is_div)) begin
            state_q  <= is_mul ? S_MUL : S_DIV;
            cnt_q    <= '0;
            neg_q    <= is_sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rneg_q   <= is_sgn && op_a[WIDTH-1];
            dz_q     <= (op_b == '0);
            is_div_q <= is_div;
            if (is_mul) begin
              acc_q   <= '0;
              mcand_q <= {{WIDTH{1'b0}}, a_abs};
              mplr_q  <= b_abs;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, a_abs};
              mcand_q <= {{WIDTH{1'b0}}, b_abs};
              mplr_q  <= '0;
            end
          end
          if (valid && funct == F_MTHI) hi_q <= op_a;
          if (valid && funct == F_MTLO) lo_q <= op_a;
        end
        S_MUL: begin
          acc_q   <= mul_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (mul_last) state_q <= S_FIX;
        end
        S_DIV: begin
          acc_q <= div_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_cpu_muldiv.md
Name: mips_cpu_muldiv

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers, serving MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Sits beside the ALU in the execute stage and is selected by the same R-type FuncCode field the ALU control decodes.
- Unlike the combinational ALU path, operations take multiple cycles. Completion is signalled through a ready/busy/done handshake, and a stall is raised for hazards.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, >=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not for override).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- valid  in  1  instruction present this cycle.
- funct  in  6  R-type FuncCode.
- op_a  in  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO data).
- op_b  in  WIDTH  rt value (multiplier/divisor).
- ready  out  1  unit can accept a start (= state IDLE).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by mult/div.
- stall  out  1  pipeline must hold current instruction.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

Behaviour:
- Reset (reset_n=0 at edge): state IDLE, HI=LO=0, counter=0, done=0, busy=0. Applies mid-operation: the operation is aborted and no partial write occurs.
- Decode: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO, 010000 MFHI, 010010 MFLO. Any other funct is ignored.
- States and transitions:
  - IDLE->MUL on MULT/MULTU accept.
  - IDLE->DIV on DIV/DIVU accept.
  - MUL/DIV->FIX after WIDTH iterations.
  - FIX->IDLE unconditionally.
- Accept: valid & start-op & state IDLE, at edge E0.
  - Signed ops latch absolute values plus result-sign flags.
  - Counter cleared.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
- DIV: restoring shift-subtract, one quotient bit per cycle.
- FIX: applies sign correction and writes HI/LO at edge E(WIDTH+1); done=1 for the following cycle.
  - busy is high from E0+ through E(WIDTH+1).
  - ready = !busy.
- MULT/MULTU result: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
- DIV/DIVU result: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero (both signed and unsigned): HI = op_a, LO = all ones. Runs full latency.
- Signed overflow (INT_MIN / -1): LO = INT_MIN, HI = 0.
- MTHI/MTLO: written at the edge when valid & IDLE; visible on hi_out/lo_out the next cycle. No done pulse.
- MFHI/MFLO are combinational reads of hi_out/lo_out; the unit changes nothing.
- stall = valid & busy & (any decoded op). This covers mult/div/MT*/MF* issued while busy.
  - A stalled op is not accepted.
  - The stalled op is re-presented by the pipeline and accepted on the first IDLE cycle.
- Start in the same cycle as FIX: stall=1. It is accepted in the next cycle (IDLE).

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: MUL goes to FIX as soon as the remaining unshifted multiplier bits are all zero (minimum 1 iteration). Latency becomes data-dependent, between 2 and WIDTH+1 cycles. DIV is unchanged.
- Undefined: fixed WIDTH+1 latency for all mult/div.

Decomposition:
- Package mips_cpu_muldiv_pkg holds:
  - state enum (IDLE, MUL, DIV, FIX);
  - localparams for the eight funct codes;
  - the divide-by-zero LO constant rule.
- One sub-module is natural: mips_cpu_muldiv_signfix, combinational negate/sign-correction of the product, quotient and remainder.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFF b=00000002 -> HI=FFFFFFFF, LO=FFFFFFFE, done 33 cycles after accept. MULTU same operands -> HI=00000001, LO=FFFFFFFE.
- DIV a=FFFFFFF9 (-7) b=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU a=7 b=2 -> LO=3, HI=1.
- DIVU a=5 b=0 -> HI=5, LO=FFFFFFFF. DIV a=80000000 b=FFFFFFFF -> LO=80000000, HI=0.
- MFLO presented at cycle 3 of a MULTU -> stall=1 until done; LO is then valid and stall=0. A second MULT during busy -> not accepted, ready=0.
- MTHI a=12345678 while idle -> hi_out=12345678 next cycle, no done pulse.
- reset_n=0 at cycle 10 of a DIV -> busy=0, HI=LO=0 after that edge, ready=1, no done. With MULDIV_EARLY_OUT_EN: MULTU b=1 -> done 2 cycles after accept.
